// File: rtl/gpp_fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding
// and default sizing of the instruction memory interface.
package gpp_fetch_pkg;

  localparam int MEM_DEPTH_DEF = 400;
  localparam int ADDR_W_DEF    = 9;
  localparam int INSTR_W_DEF   = 16;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_FETCH_REQ  = 3'd2,
    S_FETCH_WAIT = 3'd3,
    S_HOLD       = 3'd4,
    S_DONE       = 3'd5
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer. Streams the program file into instruction
// memory, then fetches words in program-counter order and presents each to
// decode. Decode may redirect the program counter with a branch.
//
// Optional trace output: define INSTR_FETCH_TRACE_EN to print every capture
// and every branch. Behaviour and timing are the same either way.
//
// Decode handshake: instr_valid rises with a captured word and instr_out is
// held stable until a cycle with instr_valid && instr_ready; that edge
// consumes the word. A branch on the same edge also consumes it, but the
// branch target wins the next pc.
import gpp_fetch_pkg::*;

module instr_fetch #(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int INSTR_W   = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               read_file,
  input  logic               fin_file,
  output logic               read_memory,
  output logic [ADDR_W-1:0]  pos,
  input  logic [INSTR_W-1:0] return_instr_line,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch_en,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  prog_len,
  output logic               busy,
  output logic               done,
  output fetch_state_e       state_dbg
);

  // Depth widened by one bit so a full memory compares without overflow.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(MEM_DEPTH);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  prog_len_q, prog_len_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;

  logic               mem_full;
  logic               fetch_active;
  logic [ADDR_W:0]    pc_inc;

  assign mem_full     = ({1'b0, prog_len_q} >= DEPTH_EXT);
  assign fetch_active = (state_q == S_FETCH_REQ) || (state_q == S_FETCH_WAIT) ||
                        (state_q == S_HOLD);
  // One extra bit so pc+1 never wraps before the length compare.
  assign pc_inc       = {1'b0, pc_q} + (ADDR_W+1)'(1);

  // Strobes are combinational from state so no load edge follows EOF, and
  // read_file / read_memory are mutually exclusive by construction.
  assign read_file   = (state_q == S_LOAD) && !fin_file && !mem_full;
  assign read_memory = (state_q == S_FETCH_REQ);
  assign pos         = (state_q == S_FETCH_REQ) ? pc_q : '0;

  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign prog_len    = prog_len_q;
  assign busy        = (state_q == S_LOAD) || fetch_active;
  assign done        = (state_q == S_DONE);
  assign state_dbg   = state_q;

  // Next-state and datapath updates; branch overrides the normal flow.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    prog_len_d = prog_len_q;
    instr_d    = instr_q;
    valid_d    = valid_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          prog_len_d = '0;
        end
      end
      S_LOAD: begin
        if (read_file) prog_len_d = prog_len_q + ADDR_W'(1);
        if (fin_file || mem_full) begin
          if (prog_len_q == '0) begin
            state_d = S_DONE;
          end else begin
            pc_d    = '0;
            state_d = S_FETCH_REQ;
          end
        end
      end
      S_FETCH_REQ: begin
        state_d = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        instr_d = return_instr_line;
        valid_d = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (instr_ready) begin
          valid_d = 1'b0;
          pc_d    = pc_inc[ADDR_W-1:0];
          state_d = (pc_inc >= {1'b0, prog_len_q}) ? S_DONE : S_FETCH_REQ;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Redirect discards any in-flight read: the capture above is undone.
    if (fetch_active && branch_en) begin
      pc_d    = branch_target;
      instr_d = instr_q;
      valid_d = 1'b0;
      state_d = (branch_target >= prog_len_q) ? S_DONE : S_FETCH_REQ;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      prog_len_q <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      prog_len_q <= prog_len_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

`ifdef INSTR_FETCH_TRACE_EN
  // Trace each capture and each redirect as it happens.
  always @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_FETCH_WAIT && !branch_en)
        $display("%0t instr_fetch: pc=%0d instr=%b", $time, pc_q, return_instr_line);
      if (fetch_active && branch_en)
        $display("%0t instr_fetch: branch pc=%0d -> %0d", $time, pc_q, branch_target);
    end
  end
`else
  // Trace disabled: no simulation output.
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a small instruction memory model.
module tb_instr_fetch;
  import gpp_fetch_pkg::*;

  localparam int AW = 9;
  localparam int IW = 16;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst, start, fin_file, instr_ready, branch_en;
  logic [AW-1:0] branch_target;
  logic          read_file, read_memory, instr_valid, busy, done;
  logic [AW-1:0] pos, pc, prog_len;
  logic [IW-1:0] return_instr_line, instr_out;
  fetch_state_e  state_dbg;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .rst(rst), .start(start), .read_file(read_file),
    .fin_file(fin_file), .read_memory(read_memory), .pos(pos),
    .return_instr_line(return_instr_line), .instr_out(instr_out),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_en(branch_en), .branch_target(branch_target), .pc(pc),
    .prog_len(prog_len), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // ---------------- memory model ----------------
  logic [IW-1:0] file_data [0:511];
  logic [IW-1:0] mem       [0:511];
  int            file_len;
  int            load_cnt;
  logic [IW-1:0] rdata;

  assign fin_file          = (load_cnt >= file_len);
  assign return_instr_line = rdata;

  always @(posedge clk) begin
    if (rst) load_cnt <= 0;
    else if (read_file) begin
      mem[load_cnt[8:0]] <= file_data[load_cnt[8:0]];
      load_cnt           <= load_cnt + 1;
    end
    if (read_memory) rdata <= mem[pos];
  end

  // ---------------- scoreboard ----------------
  int            n_cmp = 0;
  int            n_err = 0;
  logic [IW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; instr_ready = 1'b0;
    branch_en = 1'b0; branch_target = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_state"}, 32'(state_dbg), 32'(S_IDLE));
    check_eq({tag, "_rf"}, 32'(read_file), 0);
    check_eq({tag, "_rm"}, 32'(read_memory), 0);
    check_eq({tag, "_pos"}, 32'(pos), 0);
    check_eq({tag, "_instr"}, 32'(instr_out), 0);
    check_eq({tag, "_valid"}, 32'(instr_valid), 0);
    check_eq({tag, "_pc"}, 32'(pc), 0);
    check_eq({tag, "_len"}, 32'(prog_len), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!instr_valid && n < 50) begin tick(); n++; end
    check_eq({tag, "_timeout"}, 32'(instr_valid), 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 200) begin tick(); n++; end
    check_eq({tag, "_timeout"}, 32'(done), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc, rf_cnt, fin_cyc, first_valid, k, rm_cnt;
    int pos_log[$];

    file_data[0] = 16'hA001; file_data[1] = 16'hB002;
    file_data[2] = 16'hC003; file_data[3] = 16'hD004;
    for (int i = 4; i < 512; i++) file_data[i] = 16'(i * 3 + 16'h0100);
    file_len = 4;

    // Reset state
    do_reset();
    check_idle("reset");

    // 4-line file with decode always ready
    for (int i = 0; i < 4; i++) exp_q.push_back(file_data[i]);
    instr_ready = 1'b1;
    pulse_start();
    check_eq("t1_load_state", 32'(state_dbg), 32'(S_LOAD));
    cyc = 0; rf_cnt = 0; fin_cyc = -1; first_valid = -1; k = 0;
    while (!done && cyc < 100) begin
      if (read_file) rf_cnt++;
      if (fin_cyc < 0 && fin_file && state_dbg == S_LOAD) fin_cyc = cyc;
      if (first_valid < 0 && instr_valid) first_valid = cyc;
      if (read_memory) pos_log.push_back(int'(pos));
      if (instr_valid && instr_ready) begin
        if (exp_q.size() > 0) check_eq("t2_instr", 32'(instr_out), 32'(exp_q.pop_front()));
        else check_eq("t2_extra_instr", 32'(instr_valid), 0);
        check_eq("t2_pc", 32'(pc), 32'(k));
        k++;
      end
      tick(); cyc++;
    end
    check_eq("t2_done", 32'(done), 1);
    check_eq("t1_rf_count", 32'(rf_cnt), 4);
    check_eq("t1_prog_len", 32'(prog_len), 4);
    // fin_file sampled in cycle fin_cyc; the exit edge closes it, and
    // valid shows two edges later, i.e. three samples on.
    check_eq("t1_first_valid", 32'(first_valid - fin_cyc), 3);
    check_eq("t2_handshakes", 32'(k), 4);
    check_eq("t2_exp_left", 32'(exp_q.size()), 0);
    check_eq("t2_pos_count", 32'(pos_log.size()), 4);
    for (int i = 0; i < 4 && i < pos_log.size(); i++)
      check_eq("t2_pos_seq", 32'(pos_log[i]), 32'(i));
    check_eq("t2_pc_end", 32'(pc), 4);
    check_eq("t2_busy", 32'(busy), 0);
    instr_ready = 1'b0;
    pulse_start();
    check_eq("t2_done_sticky", 32'(state_dbg), 32'(S_DONE));
    check_eq("t2_done_no_load", 32'(read_file), 0);

    // Decode stalls 5 cycles in HOLD
    do_reset();
    pulse_start();
    wait_valid("t3_v0");
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t3_hold_instr", 32'(instr_out), 32'(file_data[0]));
      check_eq("t3_hold_valid", 32'(instr_valid), 1);
      check_eq("t3_hold_pc", 32'(pc), 0);
      check_eq("t3_hold_rm", 32'(read_memory), 0);
    end
    instr_ready = 1'b1; tick(); instr_ready = 1'b0;
    check_eq("t3_pc1", 32'(pc), 1);
    check_eq("t3_valid_drop", 32'(instr_valid), 0);
    wait_valid("t3_v1");
    check_eq("t3_instr1", 32'(instr_out), 32'(file_data[1]));
    instr_ready = 1'b1; tick(); instr_ready = 1'b0;
    wait_valid("t3_v2");
    check_eq("t3_instr2", 32'(instr_out), 32'(file_data[2]));
    check_eq("t3_pc2", 32'(pc), 2);

    // Branch to 0 from HOLD at pc=2, with ready also high
    branch_en = 1'b1; branch_target = 9'd0; instr_ready = 1'b1;
    tick();
    branch_en = 1'b0; instr_ready = 1'b0;
    check_eq("t4_pos", 32'(pos), 0);
    check_eq("t4_rm", 32'(read_memory), 1);
    check_eq("t4_valid", 32'(instr_valid), 0);
    check_eq("t4_pc", 32'(pc), 0);
    tick(); tick();
    check_eq("t4_valid2", 32'(instr_valid), 1);
    check_eq("t4_instr", 32'(instr_out), 32'(file_data[0]));

    // Branch past the end of a 4-word program
    branch_en = 1'b1; branch_target = 9'd7;
    tick();
    branch_en = 1'b0;
    check_eq("t5_state", 32'(state_dbg), 32'(S_DONE));
    check_eq("t5_done", 32'(done), 1);
    check_eq("t5_pc", 32'(pc), 7);
    check_eq("t5_valid", 32'(instr_valid), 0);
    rm_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (read_memory) rm_cnt++;
      tick();
    end
    check_eq("t5_no_rm", 32'(rm_cnt), 0);

    // Reset during FETCH_WAIT, then reload
    do_reset();
    pulse_start();
    cyc = 0;
    while (state_dbg != S_FETCH_WAIT && cyc < 50) begin tick(); cyc++; end
    check_eq("t6_reach_wait", 32'(state_dbg), 32'(S_FETCH_WAIT));
    rst = 1'b1; tick();
    check_idle("t6_rst");
    rst = 1'b0;
    pulse_start();
    check_eq("t6_reload_state", 32'(state_dbg), 32'(S_LOAD));
    check_eq("t6_reload_rf", 32'(read_file), 1);
    instr_ready = 1'b1;
    wait_done("t6_done");
    check_eq("t6_prog_len", 32'(prog_len), 4);
    instr_ready = 1'b0;

    // Empty file goes straight to DONE
    do_reset();
    file_len = 0;
    pulse_start();
    check_eq("t7_no_rf", 32'(read_file), 0);
    tick();
    check_eq("t7_done", 32'(done), 1);
    check_eq("t7_len", 32'(prog_len), 0);
    check_eq("t7_pc", 32'(pc), 0);

    // Oversized file stops at memory depth
    do_reset();
    file_len = 500;
    pulse_start();
    rf_cnt = 0; cyc = 0;
    while (state_dbg == S_LOAD && cyc < 600) begin
      if (read_file) rf_cnt++;
      tick(); cyc++;
    end
    check_eq("t8_rf_count", 32'(rf_cnt), 400);
    check_eq("t8_prog_len", 32'(prog_len), 400);
    check_eq("t8_state", 32'(state_dbg), 32'(S_FETCH_REQ));
    wait_valid("t8_v0");
    check_eq("t8_instr0", 32'(instr_out), 32'(file_data[0]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer that drives the instruction memory's load and read ports from the processor side. After `start`, it streams the program file into memory by pulsing `read_file` until `fin_file`, and records the program length. It then fetches instructions in order by program counter and presents each one to decode over a valid/ready handshake. Decode can redirect the program counter with a branch.

## Interface
Parameters:
- `MEM_DEPTH`, 400 — instruction memory depth in words
- `ADDR_W`, 9 — width of `pos`, `pc`, `prog_len`
- `INSTR_W`, 16 — instruction width

Ports:
- `clk` in 1 — single clock; all logic on posedge
- `rst` in 1 — synchronous, active-high reset
- `start` in 1 — begin load; sampled only in IDLE
- `read_file` out 1 — memory load strobe
- `fin_file` in 1 — memory end-of-file flag
- `read_memory` out 1 — memory read strobe
- `pos` out ADDR_W — memory read address
- `return_instr_line` in INSTR_W — memory read data, valid the cycle after the `read_memory` edge
- `instr_out` out INSTR_W — instruction to decode
- `instr_valid` out 1 — `instr_out` valid
- `instr_ready` in 1 — decode accepts
- `branch_en` in 1 — redirect request
- `branch_target` in ADDR_W — redirect address
- `pc` out ADDR_W — address of the current or pending instruction
- `prog_len` out ADDR_W — number of words loaded
- `busy` out 1 — high in LOAD, FETCH_REQ, FETCH_WAIT, HOLD
- `done` out 1 — program exhausted; sticky until `rst`

## Operation
- **Reset:** state IDLE. All outputs are 0, including `pc`, `prog_len`, `instr_out` and `done`.
- **States:** IDLE, LOAD, FETCH_REQ, FETCH_WAIT, HOLD, DONE.
- **IDLE:**
  - `start`=1 → LOAD.
- **LOAD:**
  - `read_file = (state==LOAD) && !fin_file && (prog_len < MEM_DEPTH)`. This is combinational, so no extra load edge is issued after EOF.
  - `prog_len` increments on every edge with `read_file`=1.
  - Exit when `fin_file`=1 or `prog_len`==MEM_DEPTH:
    - → DONE if `prog_len`==0.
    - otherwise `pc` is set to 0 and the state goes to FETCH_REQ.
- **FETCH_REQ:**
  - `read_memory`=1 and `pos`=`pc` for exactly one cycle.
  - → FETCH_WAIT.
- **FETCH_WAIT:**
  - On the edge, capture `return_instr_line` into `instr_out` and set `instr_valid`=1.
  - → HOLD.
- **HOLD:**
  - `instr_out` and `instr_valid` stay stable while `instr_ready`=0.
  - On `instr_ready`=1: set `instr_valid`=0 and `pc`←`pc`+1.
  - Then → DONE if the new `pc` ≥ `prog_len`, else → FETCH_REQ.
- **Branch:**
  - Honoured in FETCH_REQ, FETCH_WAIT and HOLD, and takes priority over the handshake.
  - Action: `pc`←`branch_target`, `instr_valid`←0, and any in-flight read is discarded.
  - Then → DONE if `branch_target` ≥ `prog_len`, else → FETCH_REQ.
  - In HOLD with both `branch_en` and `instr_ready` high, the held instruction counts as consumed and the branch wins the next `pc`.
- **`read_memory`/`read_file` exclusivity:** they are never high in the same cycle. `read_memory` is 0 outside FETCH_REQ.
- **DONE:**
  - `done`=1, `busy`=0; `start` is ignored.
  - Leaving DONE requires `rst`. The memory's own load counter needs its own reset for a reload; the top level owns that.
- **Widths:** `pc`+1 is computed at ADDR_W+1 bits before the compare, so no wrap occurs at 511.

## Timing
- Load throughput: one word per cycle.
- LOAD to first `instr_valid`: 2 edges after the LOAD exit edge.
- Handshake to next `instr_valid`: 2 edges, giving a peak of 1 instruction per 3 cycles.
- Branch to `instr_valid` at target: 2 edges after the branch edge.
- `rst` mid-operation: IDLE on the next edge, outputs cleared, in-flight data dropped.

## Configuration
- Macro: `INSTR_FETCH_TRACE_EN`.
  - **Defined:** on every FETCH_WAIT capture, `$display` the time, `pc` and `instr_out` in binary; on every branch, `$display` the old `pc` and the target.
  - **Undefined:** no simulation output. Functional behaviour and timing are identical in both cases.

## Structure
- Shared package `gpp_fetch_pkg` holds:
  - the state enum;
  - the `MEM_DEPTH`, `ADDR_W` and `INSTR_W` defaults.
- The block is a single module: one FSM plus the `pc` and `prog_len` registers. No sub-module is natural.

## Test plan
- 4-line file:
  - `read_file` is high for exactly 4 cycles and `prog_len`=4.
  - `instr_valid` first rises 2 edges after `fin_file` is seen.
- `instr_ready` tied to 1:
  - `pos` sequence 0,1,2,3.
  - `instr_out` matches file lines 0–3.
  - `done`=1 after the 4th handshake.
- `instr_ready` held 0 for 5 cycles in HOLD:
  - `instr_out`, `instr_valid` and `pc` are unchanged.
  - `read_memory` stays 0 throughout.
- `branch_en` with target 0 while HOLD at `pc`=2:
  - next `pos`=0.
  - `instr_out` equals line 0 two edges later.
- `branch_target`=7 with `prog_len`=4:
  - DONE on the next edge.
  - `read_memory` is never asserted.
- `rst` asserted during FETCH_WAIT:
  - next cycle is IDLE with all outputs 0.
  - a later `start` re-enters LOAD.
